// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer: control sequencer for one MNIST inference pass.
// Per start: clear accumulators, load biases, stream pixel addresses with a
// ROM-latency-matched valid, drain the MAC pipeline, then scan for the argmax.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start             begin inference (sampled only in IDLE)
//   o_busy              high in every state except IDLE
//   o_acc_clear         one-cycle accumulator clear pulse
//   o_bias_addr         bias ROM address
//   o_bias_load         one-hot bias load strobe, aligned to ROM latency
//   o_pixel_addr        pixel/weight ROM address
//   o_pixel_valid       ROM data valid for the MAC array
//   o_acc_sel           accumulator read-mux select
//   i_acc_data          signed accumulator[o_acc_sel]
//   o_class_out         predicted class
//   o_class_score       winning accumulator value
//   o_done              one-cycle completion pulse
//   o_result_valid      class outputs hold a valid result
module mnist_infer_sequencer #(
   parameter int unsigned NUM_PIXELS  = 784,
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned MAC_LATENCY = 1,
   parameter int unsigned ACC_W       = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   output logic                    o_busy,
   output logic                    o_acc_clear,
   output logic [3:0]              o_bias_addr,
   output logic [NUM_CLASSES-1:0]  o_bias_load,
   output logic [11:0]             o_pixel_addr,
   output logic                    o_pixel_valid,
   output logic [3:0]              o_acc_sel,
   input  logic signed [ACC_W-1:0] i_acc_data,
   output logic [3:0]              o_class_out,
   output logic signed [ACC_W-1:0] o_class_score,
   output logic                    o_done,
   output logic                    o_result_valid
);

   localparam int unsigned DRAIN_CYC = MEM_LATENCY + MAC_LATENCY;
   localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);
   localparam logic [3:0]         LAST_CLASS = 4'(NUM_CLASSES - 1);
   localparam logic [11:0]        LAST_PIXEL = 12'(NUM_PIXELS - 1);
   localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_BIAS, S_STREAM, S_DRAIN, S_ARGMAX, S_DONE
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [3:0]              r_bias_addr, w_bias_addr_nxt;
   logic [11:0]             r_pixel_addr, w_pixel_addr_nxt;
   logic [3:0]              r_acc_sel, w_acc_sel_nxt;
   logic [DRAIN_W-1:0]      r_drain_cnt, w_drain_cnt_nxt;
   logic [3:0]              r_best_idx, w_best_idx_nxt;
   logic signed [ACC_W-1:0] r_best_score, w_best_score_nxt;
   logic [3:0]              r_class_out, w_class_out_nxt;
   logic signed [ACC_W-1:0] r_class_score, w_class_score_nxt;
   logic                    r_result_valid, w_result_valid_nxt;
   logic                    r_busy, r_acc_clear, r_done;

   // Issue-to-strobe delay lines, MEM_LATENCY stages deep
   logic [NUM_CLASSES-1:0]  r_bl_dly [MEM_LATENCY];
   logic                    r_pv_dly [MEM_LATENCY];
   logic [NUM_CLASSES-1:0]  w_bias_onehot;

   assign w_bias_onehot = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << r_bias_addr;

   // Next-state, counter and result decode
   always_comb begin
      w_state_nxt        = r_state;
      w_bias_addr_nxt    = r_bias_addr;
      w_pixel_addr_nxt   = r_pixel_addr;
      w_acc_sel_nxt      = r_acc_sel;
      w_drain_cnt_nxt    = r_drain_cnt;
      w_best_idx_nxt     = r_best_idx;
      w_best_score_nxt   = r_best_score;
      w_class_out_nxt    = r_class_out;
      w_class_score_nxt  = r_class_score;
      w_result_valid_nxt = r_result_valid;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt        = S_CLEAR;
               w_bias_addr_nxt    = '0;
               w_pixel_addr_nxt   = '0;
               w_acc_sel_nxt      = '0;
               w_drain_cnt_nxt    = '0;
               w_result_valid_nxt = 1'b0;
            end
         end
         S_CLEAR: w_state_nxt = S_BIAS;
         S_BIAS: begin
            if (r_bias_addr == LAST_CLASS) w_state_nxt = S_STREAM;
            else w_bias_addr_nxt = r_bias_addr + 4'd1;
         end
         S_STREAM: begin
            if (r_pixel_addr == LAST_PIXEL) w_state_nxt = S_DRAIN;
            else w_pixel_addr_nxt = r_pixel_addr + 12'd1;
         end
         S_DRAIN: begin
            if (r_drain_cnt == LAST_DRAIN) w_state_nxt = S_ARGMAX;
            else w_drain_cnt_nxt = r_drain_cnt + DRAIN_W'(1);
         end
         S_ARGMAX: begin
            // Strict signed compare: ties keep the lower index
            if (r_acc_sel == 4'd0 || i_acc_data > r_best_score) begin
               w_best_idx_nxt   = r_acc_sel;
               w_best_score_nxt = i_acc_data;
            end
            if (r_acc_sel == LAST_CLASS) w_state_nxt = S_DONE;
            else w_acc_sel_nxt = r_acc_sel + 4'd1;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      // Result registers load on the edge that enters DONE
      if (w_state_nxt == S_DONE) begin
         w_class_out_nxt    = w_best_idx_nxt;
         w_class_score_nxt  = w_best_score_nxt;
         w_result_valid_nxt = 1'b1;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_bias_addr    <= '0;
         r_pixel_addr   <= '0;
         r_acc_sel      <= '0;
         r_drain_cnt    <= '0;
         r_best_idx     <= '0;
         r_best_score   <= '0;
         r_class_out    <= '0;
         r_class_score  <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_acc_clear    <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_bias_addr    <= w_bias_addr_nxt;
         r_pixel_addr   <= w_pixel_addr_nxt;
         r_acc_sel      <= w_acc_sel_nxt;
         r_drain_cnt    <= w_drain_cnt_nxt;
         r_best_idx     <= w_best_idx_nxt;
         r_best_score   <= w_best_score_nxt;
         r_class_out    <= w_class_out_nxt;
         r_class_score  <= w_class_score_nxt;
         r_result_valid <= w_result_valid_nxt;
         r_busy         <= (w_state_nxt != S_IDLE);
         r_acc_clear    <= (w_state_nxt == S_CLEAR);
         r_done         <= (w_state_nxt == S_DONE);
      end
   end

   // Delay lines keep shifting across state boundaries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            r_bl_dly[i] <= '0;
            r_pv_dly[i] <= 1'b0;
         end
      end else begin
         r_bl_dly[0] <= (r_state == S_BIAS) ? w_bias_onehot : '0;
         r_pv_dly[0] <= (r_state == S_STREAM);
         for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            r_bl_dly[i] <= r_bl_dly[i-1];
            r_pv_dly[i] <= r_pv_dly[i-1];
         end
      end
   end

   assign o_busy         = r_busy;
   assign o_acc_clear    = r_acc_clear;
   assign o_bias_addr    = r_bias_addr;
   assign o_bias_load    = r_bl_dly[MEM_LATENCY-1];
   assign o_pixel_addr   = r_pixel_addr;
   assign o_pixel_valid  = r_pv_dly[MEM_LATENCY-1];
   assign o_acc_sel      = r_acc_sel;
   assign o_class_out    = r_class_out;
   assign o_class_score  = r_class_score;
   assign o_done         = r_done;
   assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// tb_mnist_infer_sequencer: directed bench for mnist_infer_sequencer.
// Two instances: defaults (a_*) and a small configuration (b_*: 16 pixels,
// 4 classes, ROM latency 1). A per-cycle monitor compares every strobe and
// address against the hand-derived schedule of the selected instance.
module tb_mnist_infer_sequencer;

   localparam int unsigned ACC_W = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, a_start, b_start;

   logic                    a_busy, a_acc_clear, a_pixel_valid, a_done, a_rv;
   logic [3:0]              a_bias_addr, a_acc_sel, a_class_out;
   logic [9:0]              a_bias_load;
   logic [11:0]             a_pixel_addr;
   logic signed [ACC_W-1:0] a_acc_data, a_class_score;

   logic                    b_busy, b_acc_clear, b_pixel_valid, b_done, b_rv;
   logic [3:0]              b_bias_addr, b_acc_sel, b_class_out;
   logic [3:0]              b_bias_load;
   logic [11:0]             b_pixel_addr;
   logic signed [ACC_W-1:0] b_acc_data, b_class_score;

   int acc_tbl [16];

   always_comb begin
      a_acc_data = ACC_W'(acc_tbl[a_acc_sel]);
      b_acc_data = ACC_W'(acc_tbl[b_acc_sel]);
   end

   mnist_infer_sequencer u_dut_a (
      .clk(clk), .rst(rst), .i_start(a_start), .o_busy(a_busy),
      .o_acc_clear(a_acc_clear), .o_bias_addr(a_bias_addr), .o_bias_load(a_bias_load),
      .o_pixel_addr(a_pixel_addr), .o_pixel_valid(a_pixel_valid), .o_acc_sel(a_acc_sel),
      .i_acc_data(a_acc_data), .o_class_out(a_class_out), .o_class_score(a_class_score),
      .o_done(a_done), .o_result_valid(a_rv));

   mnist_infer_sequencer #(.NUM_PIXELS(16), .NUM_CLASSES(4), .MEM_LATENCY(1),
                           .MAC_LATENCY(1), .ACC_W(24)) u_dut_b (
      .clk(clk), .rst(rst), .i_start(b_start), .o_busy(b_busy),
      .o_acc_clear(b_acc_clear), .o_bias_addr(b_bias_addr), .o_bias_load(b_bias_load),
      .o_pixel_addr(b_pixel_addr), .o_pixel_valid(b_pixel_valid), .o_acc_sel(b_acc_sel),
      .i_acc_data(b_acc_data), .o_class_out(b_class_out), .o_class_score(b_class_score),
      .o_done(b_done), .o_result_valid(b_rv));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Monitor selection and schedule parameters
   bit sel_b  = 1'b0;
   bit mon_on = 1'b0;
   int cyc    = -1;
   int nc, np, ml, mac_l, n_end;

   logic        m_busy, m_clr, m_pv, m_done, m_rv;
   logic [3:0]  m_bias_addr, m_acc_sel;
   logic [15:0] m_bias_load;
   logic [11:0] m_pixel_addr;

   always_comb begin
      m_busy       = sel_b ? b_busy        : a_busy;
      m_clr        = sel_b ? b_acc_clear   : a_acc_clear;
      m_pv         = sel_b ? b_pixel_valid : a_pixel_valid;
      m_done       = sel_b ? b_done        : a_done;
      m_rv         = sel_b ? b_rv          : a_rv;
      m_bias_addr  = sel_b ? b_bias_addr   : a_bias_addr;
      m_acc_sel    = sel_b ? b_acc_sel     : a_acc_sel;
      m_bias_load  = sel_b ? 16'(b_bias_load) : 16'(a_bias_load);
      m_pixel_addr = sel_b ? b_pixel_addr  : a_pixel_addr;
   end

   int sched_err, bl_cnt, pv_cnt, clr_cnt, done_cnt, done_cyc, overlap, first_pv, first_bl;
   logic rv0;

   // cyc = number of edges since the start-sampling edge (edge 0 -> cyc 0)
   always @(posedge clk) if (mon_on) cyc = cyc + 1;

   always @(negedge clk) begin : mon
      int c, as;
      logic [15:0] exp_bl;
      logic exp_pv;
      if (mon_on && cyc >= 0 && cyc <= n_end + 1) begin
         c  = cyc;
         as = nc + np + ml + mac_l + 1;
         exp_bl = (c >= 1 + ml && c <= nc + ml) ? (16'(1) << (c - 1 - ml)) : 16'(0);
         exp_pv = (c >= 1 + nc + ml && c <= nc + np + ml);
         if (m_bias_load != exp_bl) sched_err++;
         if (m_pv != exp_pv) sched_err++;
         if (c >= 1 && c <= nc && m_bias_addr != 4'(c - 1)) sched_err++;
         if (c >= 1 + nc && c <= nc + np && m_pixel_addr != 12'(c - 1 - nc)) sched_err++;
         if (c > nc + np && m_pixel_addr != 12'(np - 1)) sched_err++;
         if (c >= as && c < as + nc && m_acc_sel != 4'(c - as)) sched_err++;
         if (m_busy != (c <= n_end)) sched_err++;
         if (m_done != (c == n_end)) sched_err++;
         if (m_clr != (c == 0)) sched_err++;
         if (m_bias_load != 16'd0) begin
            bl_cnt++;
            if (first_bl < 0) first_bl = c;
         end
         if (m_pv) begin
            pv_cnt++;
            if (first_pv < 0) first_pv = c;
         end
         if (m_pv && m_bias_load != 16'd0) overlap++;
         if (m_clr) clr_cnt++;
         if (m_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 0) rv0 = m_rv;
      end
   end

   // One full run: pulse start, optionally poke start while busy, wait past done
   task automatic run(input bit use_b, input bit inject, output bit ok);
      bit st;
      sel_b = use_b;
      sched_err = 0; bl_cnt = 0; pv_cnt = 0; clr_cnt = 0; done_cnt = 0;
      overlap = 0; done_cyc = -1; first_pv = -1; first_bl = -1; rv0 = 1'b1;
      if (use_b) b_start = 1'b1; else a_start = 1'b1;
      cyc = -1;
      mon_on = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         st = inject && (cyc == 400 || cyc == n_end - 4);
         if (use_b) b_start = st; else a_start = st;
         if (cyc >= n_end + 1) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      mon_on = 1'b0;
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic set_tbl(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
      acc_tbl[0] = v0; acc_tbl[1] = v1; acc_tbl[2] = v2; acc_tbl[3] = v3;
      acc_tbl[4] = v4; acc_tbl[5] = v5; acc_tbl[6] = v6; acc_tbl[7] = v7;
      acc_tbl[8] = v8; acc_tbl[9] = v9;
      for (int i = 10; i < 16; i++) acc_tbl[i] = 0;
   endtask

   bit ok;
   int hit, after_bad;

   initial begin
      rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
      set_tbl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nc = 10; np = 784; ml = 2; mac_l = 1; n_end = 808;
      repeat (3) @(negedge clk);
      check("rst_busy",        a_busy, 0);
      check("rst_acc_clear",   a_acc_clear, 0);
      check("rst_bias_load",   a_bias_load, 0);
      check("rst_pixel_valid", a_pixel_valid, 0);
      check("rst_result",      {a_class_out, a_class_score, a_rv, a_done, a_acc_sel}, 0);
      check("rst_b_outputs",   {b_busy, b_bias_load, b_pixel_valid, b_rv, b_class_out}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Run 1: defaults, tie at 17 keeps index 2
      set_tbl(5, -3, 17, 17, 2, 0, -100, 9, 16, 1);
      run(1'b0, 1'b0, ok);
      check("r1_finished", ok, 1);
      check("r1_schedule", sched_err, 0);
      check("r1_clear_cnt", clr_cnt, 1);
      check("r1_bias_cnt", bl_cnt, 10);
      check("r1_first_bias", first_bl, 3);
      check("r1_pixel_cnt", pv_cnt, 784);
      check("r1_first_pixel", first_pv, 13);
      check("r1_done_edge", done_cyc, 808);
      check("r1_done_cnt", done_cnt, 1);
      check("r1_overlap", overlap, 0);
      check("r1_class", a_class_out, 2);
      check("r1_score", a_class_score, 17);
      check("r1_valid", a_rv, 1);

      // Run 2: all negative, start poked during STREAM and ARGMAX
      set_tbl(-50, -7, -9, -20, -33, -8, -12, -7, -45, -60);
      run(1'b0, 1'b1, ok);
      check("r2_finished", ok, 1);
      check("r2_schedule", sched_err, 0);
      check("r2_valid_cleared", rv0, 0);
      check("r2_bias_cnt", bl_cnt, 10);
      check("r2_pixel_cnt", pv_cnt, 784);
      check("r2_done_cnt", done_cnt, 1);
      check("r2_done_edge", done_cyc, 808);
      check("r2_class", a_class_out, 1);
      check("r2_score", a_class_score, -7);
      repeat (5) @(negedge clk);
      check("r2_busy_idle", a_busy, 0);
      check("r2_valid_held", a_rv, 1);

      // Reset in the middle of STREAM
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      hit = 0;
      for (int k = 0; k < 1000; k++) begin
         if (a_pixel_addr == 12'd400) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      check("mr_reached_400", hit, 1);
      rst = 1'b1;
      #1;
      check("mr_busy", a_busy, 0);
      check("mr_pixel_valid", a_pixel_valid, 0);
      check("mr_pixel_addr", a_pixel_addr, 0);
      check("mr_others", {a_acc_clear, a_bias_load, a_bias_addr, a_acc_sel,
                          a_class_out, a_class_score, a_rv, a_done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      after_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (a_pixel_valid || a_bias_load != 10'd0 || a_busy) after_bad++;
      end
      check("mr_quiet_after", after_bad, 0);
      run(1'b0, 1'b0, ok);
      check("mr_rerun_finished", ok, 1);
      check("mr_rerun_schedule", sched_err, 0);
      check("mr_rerun_pixel_cnt", pv_cnt, 784);
      check("mr_rerun_done_edge", done_cyc, 808);
      check("mr_rerun_class", a_class_out, 1);

      // Small configuration: 16 pixels, 4 classes, ROM latency 1
      nc = 4; np = 16; ml = 1; mac_l = 1; n_end = 27;
      set_tbl(3, -1, 8, 2, 100, 100, 100, 100, 100, 100);
      run(1'b1, 1'b0, ok);
      check("b_finished", ok, 1);
      check("b_schedule", sched_err, 0);
      check("b_bias_cnt", bl_cnt, 4);
      check("b_first_bias", first_bl, 2);
      check("b_pixel_cnt", pv_cnt, 16);
      check("b_first_pixel", first_pv, 6);
      check("b_done_edge", done_cyc, 27);
      check("b_class", b_class_out, 2);
      check("b_score", b_class_score, 8);
      check("b_valid", b_rv, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mnist_infer_sequencer.md
Name: mnist_infer_sequencer

Overview:
Top-level sequencer for one MNIST inference pass.
- Sequence per `start`: clear neuron accumulators, load the NUM_CLASSES biases from bias ROM, stream all NUM_PIXELS pixel addresses into pixel/weight ROMs with a latency-matched valid, wait for the MAC pipeline to drain, then scan the accumulators for the argmax.
- Sits between the host/start logic and the neuron MAC array; sole driver of ROM addresses and neuron control strobes.

Parameters:
- NUM_PIXELS, 784, pixels per image (1..4096).
- NUM_CLASSES, 10, neurons/classes (2..16).
- MEM_LATENCY, 2, ROM read latency in cycles (1..4); applies to bias and pixel ROMs.
- MAC_LATENCY, 1, cycles from pixel_valid to accumulator update visible on acc_data.
- ACC_W, 24, accumulator width, signed two's complement.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin inference; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- acc_clear  out  1  one-cycle pulse zeroing all accumulators.
- bias_addr  out  4  bias ROM address.
- bias_load  out  NUM_CLASSES  one-hot; bit k loads ROM data into neuron k's accumulator.
- pixel_addr  out  12  pixel/weight ROM address.
- pixel_valid  out  1  ROM data valid for MAC.
- acc_sel  out  4  accumulator read-mux select.
- acc_data  in  ACC_W  signed; combinational mux output of accumulator[acc_sel].
- class_out  out  4  predicted digit.
- class_score  out  ACC_W  winning accumulator value.
- done  out  1  one-cycle completion pulse.
- result_valid  out  1  class_out/class_score hold a valid result.

Behaviour:
- Reset: all outputs 0, including class_out, class_score, result_valid, bias_load and acc_sel; state = IDLE; delay lines cleared.
- States: IDLE -> CLEAR -> BIAS -> STREAM -> DRAIN -> ARGMAX -> DONE -> IDLE.
- IDLE: on start=1, go to CLEAR; result_valid drops to 0 on the same edge.
- CLEAR: acc_clear=1 for exactly 1 cycle.
- BIAS: NUM_CLASSES cycles; bias_addr = 0,1,…,NUM_CLASSES-1, one per cycle.
- STREAM: NUM_PIXELS cycles; pixel_addr = 0,1,…,NUM_PIXELS-1, one per cycle; holds the last value afterwards until the next run, which resets it to 0.
- DRAIN: exactly MEM_LATENCY+MAC_LATENCY cycles, no issue.
- ARGMAX: NUM_CLASSES cycles; acc_sel = 0…NUM_CLASSES-1.
  - Index 0 initialises best_score/best_idx.
  - Later indices replace best only if acc_data > best_score (signed, strict). Ties keep the lower index.
- DONE: 1 cycle; done=1, class_out=best_idx, class_score=best_score, result_valid=1 (held until next start or reset). Next state IDLE.
- Latency match: bias_load bit k asserts exactly MEM_LATENCY cycles after bias_addr==k was issued.
  - pixel_valid asserts MEM_LATENCY cycles after each pixel issue cycle.
  - Exactly NUM_CLASSES bias_load pulses and NUM_PIXELS pixel_valid pulses per run.
  - Delay lines keep shifting across state boundaries, so trailing bias_load pulses appear in early STREAM cycles. bias_load and pixel_valid are never high in the same cycle.
- Total: done is high in the cycle following edge N after the start-sampling edge, where N = 1 + 2·NUM_CLASSES + NUM_PIXELS + MEM_LATENCY + MAC_LATENCY (defaults: 808). busy falls the edge after done.
- start while busy: ignored, no effect. start held high continuously: a new run begins on the first IDLE cycle after DONE.
- Reset mid-run: immediate return to IDLE with all outputs 0. No residual bias_load/pixel_valid pulses after reset release.
- Address widths: counters never wrap; terminal compare is count == param-1.

Test Plan:
- Reset then single start pulse, defaults -> acc_clear exactly 1 cycle; bias_load pulses 0x001…0x200 in order, each 2 cycles after its bias_addr; 784 pixel_valid pulses, first 2 cycles after pixel_addr=0; done at edge 808; busy low after.
- Accumulator model returns {5,-3,17,17,2,0,-100,9,16,1} -> class_out=2, class_score=17 (tie keeps lower index), result_valid=1.
- All accumulators negative {-50,-7,-9,…,-60} -> class_out=1, class_score=-7 (signed compare).
- start pulsed during STREAM and ARGMAX -> no restart; exactly one done, pulse counts unchanged; then start in IDLE -> second run clears result_valid, identical timing.
- rst asserted at pixel_addr=400 -> all outputs 0 immediately; no pixel_valid after release; fresh start gives full 784-pulse run.
- MEM_LATENCY=1, NUM_PIXELS=16, NUM_CLASSES=4 -> pixel_valid 1 cycle after issue, 16 pulses, bias_load 4 pulses, done at edge 1+8+16+1+1=27.
